// File: rtl/accum_requantizer.sv
// Requantizes the final partial sum of an upstream accumulator tree: captures the
// last partial of each sum, rounds/shifts/saturates it, and queues it in a 2-deep FIFO.
module accum_requantizer #(
  parameter int ACC_BITWIDTH = 10,
  parameter int OUT_BITWIDTH = 8,
  parameter int LOG2_NO_IN   = 1,
  parameter int LOOP_BW      = 8,
  parameter int SHIFT_BW     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_sum,
  input  logic signed [ACC_BITWIDTH-1:0] acc_in,
  input  logic        [LOOP_BW-1:0]      loops,
  input  logic        [SHIFT_BW-1:0]     shift,
  input  logic                           relu_en,
  output logic signed [OUT_BITWIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic        [2:0]              err_flags
);
  localparam int D = LOG2_NO_IN + 1;
  localparam logic signed [ACC_BITWIDTH:0] SMAX = (ACC_BITWIDTH+1)'((2**(OUT_BITWIDTH-1)) - 1);
  localparam logic signed [ACC_BITWIDTH:0] SMIN = (ACC_BITWIDTH+1)'(-(2**(OUT_BITWIDTH-1)));
  localparam logic signed [OUT_BITWIDTH-1:0] OMAX = {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
  localparam logic signed [OUT_BITWIDTH-1:0] OMIN = {1'b1, {(OUT_BITWIDTH-1){1'b0}}};

  logic [D-1:0]         ns_pipe;
  logic                 ns_d;
  logic                 active;
  logic [LOOP_BW-1:0]   cnt, loops_h;
  logic [SHIFT_BW-1:0]  shift_h;
  logic                 relu_h;

  logic [LOOP_BW-1:0]   lim_in, cur_lim, cur_cnt;
  logic [SHIFT_BW-1:0]  cur_shift;
  logic                 cur_relu, cur_active, cap, short_sum;
  logic signed [ACC_BITWIDTH-1:0] v;
  logic        [ACC_BITWIDTH:0]   rnd;
  logic signed [ACC_BITWIDTH:0]   r_next;

  logic                           v1, v2;
  logic signed [ACC_BITWIDTH:0]   r1, s;
  logic        [SHIFT_BW-1:0]     sh1;
  logic signed [OUT_BITWIDTH-1:0] s2, sat_val;
  logic                           sat;

  logic signed [OUT_BITWIDTH-1:0] mem [2];
  logic                           wr_ptr, rd_ptr;
  logic [1:0]                     count;
  logic                           pop, push_ok, drop;

  assign ns_d = ns_pipe[D-1];

  // The ns_d cycle itself is count 0 of the new sum, so its parameters apply immediately.
  always_comb begin
    lim_in     = (loops == '0) ? LOOP_BW'(1) : loops;
    cur_lim    = ns_d ? lim_in  : loops_h;
    cur_shift  = ns_d ? shift   : shift_h;
    cur_relu   = ns_d ? relu_en : relu_h;
    cur_cnt    = ns_d ? '0      : cnt;
    cur_active = ns_d | active;
    cap        = cur_active && (cur_cnt == cur_lim - 1'b1);
    short_sum  = ns_d && active && (cnt != loops_h - 1'b1);
    v          = (cur_relu && acc_in < 0) ? '0 : acc_in;
    rnd        = '0;
    if (cur_shift != '0)
      rnd = {{ACC_BITWIDTH{1'b0}}, 1'b1} << (cur_shift - 1'b1);
    r_next     = $signed({v[ACC_BITWIDTH-1], v}) + $signed(rnd);
  end

  always_comb begin
    s       = r1 >>> sh1;
    sat     = 1'b0;
    sat_val = s[OUT_BITWIDTH-1:0];
    if (s > SMAX) begin
      sat_val = OMAX;
      sat     = 1'b1;
    end else if (s < SMIN) begin
      sat_val = OMIN;
      sat     = 1'b1;
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push_ok   = v2 && (count != 2'd2 || pop);
  assign drop      = v2 && count == 2'd2 && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_pipe   <= '0;
      active    <= 1'b0;
      cnt       <= '0;
      loops_h   <= '0;
      shift_h   <= '0;
      relu_h    <= 1'b0;
      v1        <= 1'b0;
      r1        <= '0;
      sh1       <= '0;
      v2        <= 1'b0;
      s2        <= '0;
      err_flags <= '0;
    end else begin
      ns_pipe <= (ns_pipe << 1) | D'(new_sum);
      if (ns_d) begin
        loops_h <= lim_in;
        shift_h <= shift;
        relu_h  <= relu_en;
      end
      if (cap) active <= 1'b0;
      else if (cur_active) begin
        active <= 1'b1;
        cnt    <= cur_cnt + 1'b1;
      end
      if (short_sum) err_flags[0] <= 1'b1;
      v1 <= cap;
      if (cap) begin
        r1  <= r_next;
        sh1 <= cur_shift;
      end
      v2 <= v1;
      if (v1) begin
        s2 <= sat_val;
        if (sat) err_flags[2] <= 1'b1;
      end
      if (drop) err_flags[1] <= 1'b1;
    end
  end

  // Output FIFO; a full FIFO still accepts a push when the head pops on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= s2;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_accum_requantizer.sv
// Bench for accum_requantizer: hand-computed vector table, directed corner sequences,
// and a randomized run checked every cycle against a sum-level reference model.
module tb_accum_requantizer;
  localparam int ACC = 10, OUTW = 8, L2 = 1, LBW = 8, SBW = 4, D = L2 + 1;

  logic clk = 1'b0;
  logic rst, new_sum, relu_en, out_ready, out_valid;
  logic signed [ACC-1:0]  acc_in;
  logic        [LBW-1:0]  loops;
  logic        [SBW-1:0]  shift;
  logic signed [OUTW-1:0] out_data;
  logic        [2:0]      err_flags;

  always #5 clk = ~clk;

  accum_requantizer #(.ACC_BITWIDTH(ACC), .OUT_BITWIDTH(OUTW), .LOG2_NO_IN(L2),
                      .LOOP_BW(LBW), .SHIFT_BW(SBW)) dut (
    .clk(clk), .rst(rst), .new_sum(new_sum), .acc_in(acc_in), .loops(loops),
    .shift(shift), .relu_en(relu_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_flags(err_flags));

  int checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sums tracked by start cycle and deadline, results as a plain queue.
  typedef struct { int edge_n; int val; bit sat; } pend_t;
  int     nsq[$];
  int     fifo_q[$];
  pend_t  pend[$];
  bit     m_open, m_rl;
  int     m_deadline, m_sh, k;
  bit [2:0] m_flags;

  function automatic int requant(input int acc, input int sh, input bit rl, output bit sat);
    int vv, r, q;
    vv  = (rl && acc < 0) ? 0 : acc;
    r   = vv + ((sh > 0) ? (1 << (sh - 1)) : 0);
    q   = r >>> sh;
    sat = 1'b0;
    if (q > 127)  begin q = 127;  sat = 1'b1; end
    if (q < -128) begin q = -128; sat = 1'b1; end
    return q;
  endfunction

  function automatic void model_reset();
    nsq = {};
    for (int i = 0; i < D; i++) nsq.push_back(0);
    fifo_q = {};
    pend = {};
    m_open = 1'b0;
    m_flags = '0;
    k = 0;
  endfunction

  task automatic step();
    int nsd, val, e;
    bit pop, sat;
    pend_t p;
    nsd = nsq.pop_front();
    nsq.push_back(int'(new_sum));
    pop = (fifo_q.size() > 0) && out_ready;
    e = k + 1;
    if (nsd != 0) begin
      if (m_open && k != m_deadline) m_flags[0] = 1'b1;
      m_open = 1'b1;
      m_deadline = k + ((loops == 0) ? 1 : int'(loops)) - 1;
      m_sh = int'(shift);
      m_rl = relu_en;
    end
    if (m_open && k == m_deadline) begin
      val = requant(int'(acc_in), m_sh, m_rl, sat);
      p.edge_n = e; p.val = val; p.sat = sat;
      pend.push_back(p);
      m_open = 1'b0;
    end
    foreach (pend[i]) if (pend[i].edge_n + 1 == e && pend[i].sat) m_flags[2] = 1'b1;
    if (pop) void'(fifo_q.pop_front());
    while (pend.size() > 0 && pend[0].edge_n + 2 == e) begin
      p = pend.pop_front();
      if (fifo_q.size() == 2) m_flags[1] = 1'b1;
      else fifo_q.push_back(p.val);
    end
    @(posedge clk);
    #1;
    k++;
    check("model_valid", int'(out_valid), int'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) check("model_data", int'(out_data), fifo_q[0]);
    check("model_flags", int'(err_flags), int'(m_flags));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_sum = 1'b0;
    #2;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_flags", int'(err_flags), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct { int acc; int sh; bit rl; int exp_out; bit exp_sat; } vec_t;
  vec_t tbl[15];

  initial begin
    rst = 1'b1; new_sum = 1'b0; acc_in = '0; loops = LBW'(1); shift = '0;
    relu_en = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;

    tbl[0]  = '{-100, 0, 1'b1,    0, 1'b0};
    tbl[1]  = '{ 511, 0, 1'b0,  127, 1'b1};
    tbl[2]  = '{  -9, 2, 1'b0,   -2, 1'b0};
    tbl[3]  = '{-512, 0, 1'b0, -128, 1'b1};
    tbl[4]  = '{-128, 0, 1'b0, -128, 1'b0};
    tbl[5]  = '{ 127, 0, 1'b0,  127, 1'b0};
    tbl[6]  = '{ 128, 0, 1'b0,  127, 1'b1};
    tbl[7]  = '{   6, 2, 1'b0,    2, 1'b0};
    tbl[8]  = '{   5, 1, 1'b0,    3, 1'b0};
    tbl[9]  = '{  -5, 1, 1'b0,   -2, 1'b0};
    tbl[10] = '{ 511, 2, 1'b0,  127, 1'b1};
    tbl[11] = '{ 509, 2, 1'b0,  127, 1'b0};
    tbl[12] = '{  -3, 1, 1'b1,    0, 1'b0};
    tbl[13] = '{ 100, 9, 1'b0,    0, 1'b0};
    tbl[14] = '{-129, 0, 1'b0, -128, 1'b1};

    for (int i = 0; i < 15; i++) begin
      do_reset();
      loops = LBW'(1); shift = SBW'(tbl[i].sh); relu_en = tbl[i].rl; out_ready = 1'b0;
      acc_in = ACC'(33);
      new_sum = 1'b1; step();
      new_sum = 1'b0; step();
      acc_in = ACC'(tbl[i].acc); step();
      acc_in = ACC'(-77); step();
      step();
      check("tbl_valid", int'(out_valid), 1);
      check("tbl_data", int'(out_data), tbl[i].exp_out);
      check("tbl_sat", int'(err_flags[2]), int'(tbl[i].exp_sat));
    end

    // Three-cycle sum with rounding shift; result visible after edge 7.
    do_reset();
    loops = LBW'(3); shift = SBW'(2); relu_en = 1'b0; out_ready = 1'b0; acc_in = '0;
    new_sum = 1'b1; step();
    new_sum = 1'b0; step();
    acc_in = ACC'(5); step();
    acc_in = ACC'(12); step();
    acc_in = ACC'(-9); step();
    acc_in = ACC'(33); step();
    check("lat_early", int'(out_valid), 0);
    step();
    check("lat_valid", int'(out_valid), 1);
    check("lat_data", int'(out_data), -2);

    // Second new_sum interrupts a four-cycle sum.
    do_reset();
    loops = LBW'(4); shift = '0; relu_en = 1'b0; out_ready = 1'b1; acc_in = ACC'(40);
    new_sum = 1'b1; step();
    new_sum = 1'b0; step();
    new_sum = 1'b1; step();
    new_sum = 1'b0; step();
    step();
    check("short_flag", int'(err_flags[0]), 1);
    repeat (4) begin
      step();
      check("short_no_first", int'(out_valid), 0);
    end
    step();
    check("short_valid", int'(out_valid), 1);
    check("short_data", int'(out_data), 40);
    step();
    check("short_drained", int'(out_valid), 0);

    // Four back-to-back results into a stalled 2-entry FIFO.
    do_reset();
    loops = LBW'(1); shift = '0; relu_en = 1'b0; out_ready = 1'b0; acc_in = '0;
    new_sum = 1'b1; step();
    step();
    acc_in = ACC'(10); step();
    acc_in = ACC'(20); step();
    new_sum = 1'b0; acc_in = ACC'(30); step();
    acc_in = ACC'(40); step();
    step(); step();
    check("ovf_flag", int'(err_flags[1]), 1);
    check("ovf_valid", int'(out_valid), 1);
    check("ovf_head", int'(out_data), 10);
    out_ready = 1'b1; step();
    check("ovf_second_valid", int'(out_valid), 1);
    check("ovf_second", int'(out_data), 20);
    step();
    check("ovf_empty", int'(out_valid), 0);

    // Reset one cycle after capture discards the in-flight result.
    do_reset();
    loops = LBW'(1); shift = '0; relu_en = 1'b0; out_ready = 1'b1; acc_in = '0;
    new_sum = 1'b1; step();
    new_sum = 1'b0; step();
    acc_in = ACC'(77); step();
    acc_in = '0; step();
    do_reset();
    repeat (5) step();
    new_sum = 1'b1; step();
    new_sum = 1'b0; step();
    acc_in = ACC'(-77); step();
    acc_in = '0; step(); step();
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_data", int'(out_data), -77);

    // One result per cycle with loops=1 and the consumer always ready.
    do_reset();
    loops = LBW'(1); shift = SBW'(1); relu_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      new_sum = (i < 8);
      acc_in = ACC'(int'($urandom_range(0, 1023)) - 512);
      step();
      if (i >= 4) check("tput_valid", int'(out_valid), 1);
    end
    step();
    check("tput_no_ovf", int'(err_flags[1]), 0);

    // Randomized traffic, parameters changing every cycle.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      new_sum = ($urandom_range(0, 2) == 0);
      acc_in = ACC'(int'($urandom_range(0, 1023)) - 512);
      loops = LBW'($urandom_range(0, 4));
      shift = SBW'($urandom_range(0, 9));
      relu_en = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 700) do_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
